// File: rtl/sp_bsram_port_ctrl_if.sv
// Request/response stream bundle between an initiator and the SP block-SRAM port controller.
// The master drives requests and response backpressure; the slave (controller) returns ready and data.
interface sp_bsram_port_ctrl_if #(
  parameter int ADDR_W = 9
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [3:0]        req_be;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sp_bsram_port_ctrl.sv
// Initiator-side controller for a 32-bit SP single-port block SRAM: zero-cycle issue of CE/WRE/AD/DI,
// read-latency tracking for bypass/pipeline modes, and a credit-gated fall-through response FIFO.

module sp_bsram_port_ctrl_chk #(
  parameter int RSP_DEPTH = 2,
  parameter int CW        = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] count,
  input logic          rsp_valid,
  input logic          rsp_ready,
  input logic [31:0]   rsp_rdata
);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (push && !pop) |-> (32'(count) < RSP_DEPTH))
    else $error("response fifo overflow");

  a_rsp_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata)))
    else $error("response changed while stalled");
endmodule

module sp_bsram_port_ctrl #(
  parameter logic READ_MODE = 1'b0,
  parameter int   ADDR_W    = 9,
  parameter int   RSP_DEPTH = 2
) (
  input  logic                CLK,
  input  logic                RESETN,
  sp_bsram_port_ctrl_if.slave bus,
  output logic                sp_ce,
  output logic                sp_wre,
  output logic                sp_oce,
  output logic                sp_reset,
  output logic [13:0]         sp_ad,
  output logic [31:0]         sp_di,
  input  logic [31:0]         sp_do
);
  localparam int              CW       = $clog2(RSP_DEPTH + 1);
  localparam int              PW       = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CW:0]     DEPTH_C  = (CW+1)'(RSP_DEPTH);
  localparam logic [PW-1:0]   LAST_PTR = PW'(RSP_DEPTH - 1);

  logic [1:0]    r_rd_pipe;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [31:0]   r_mem [RSP_DEPTH];
  logic          r_sp_reset;

  logic          w_req_ready;
  logic          w_issue;
  logic          w_rd_issue;
  logic          w_arrive;
  logic          w_empty;
  logic          w_push;
  logic          w_pop_head;
  logic          w_rsp_valid;
  logic [31:0]   w_rsp_rdata;
  logic [1:0]    w_inflight;
  logic [CW:0]   w_credit_used;
  logic [8:0]    w_addr9;
  logic [13:0]   w_ad;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return PW'(0);
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign w_addr9 = 9'(bus.req_addr);

  // Read data still owed by the SRAM, and the credit it plus the FIFO consumes.
  always_comb begin
    w_inflight = 2'b00;
    w_arrive   = 1'b0;
    if (READ_MODE) begin
      w_inflight = 2'(r_rd_pipe[0]) + 2'(r_rd_pipe[1]);
      w_arrive   = r_rd_pipe[1];
    end else begin
      w_inflight = 2'(r_rd_pipe[0]);
      w_arrive   = r_rd_pipe[0];
    end
    w_credit_used = (CW+1)'(r_count) + (CW+1)'(w_inflight);
  end

  // Writes never need credit; reads only when a response slot is guaranteed.
  always_comb begin
    w_req_ready = 1'b0;
    if (!RESETN) begin
      w_req_ready = 1'b0;
    end else if (bus.req_we) begin
      w_req_ready = 1'b1;
    end else begin
      w_req_ready = (w_credit_used < DEPTH_C);
    end
  end

  assign w_issue    = bus.req_valid & w_req_ready;
  assign w_rd_issue = w_issue & ~bus.req_we;

  // SP address word: word address on [13:5], byte enables on [3:0] for writes only.
  always_comb begin
    w_ad = 14'h0000;
    if (w_issue) begin
      w_ad[13:5] = w_addr9;
      w_ad[4]    = 1'b0;
      if (bus.req_we) begin
        w_ad[3:0] = bus.req_be;
      end else begin
        w_ad[3:0] = 4'b0000;
      end
    end else begin
      w_ad = 14'h0000;
    end
  end

  // Fall-through: an arriving word may leave directly when the FIFO is empty and the consumer is ready.
  assign w_empty    = (r_count == CW'(0));
  assign w_pop_head = ~w_empty & bus.rsp_ready;
  assign w_push     = w_arrive & ~(w_empty & bus.rsp_ready);
  assign w_rsp_valid = RESETN & (~w_empty | w_arrive);

  always_comb begin
    w_rsp_rdata = 32'h0000_0000;
    if (w_empty) begin
      w_rsp_rdata = sp_do;
    end else begin
      w_rsp_rdata = r_mem[r_rd_ptr];
    end
  end

  // Read latency shift register: bit 0 marks a read issued at the last edge.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_rd_pipe <= 2'b00;
    end else begin
      r_rd_pipe <= {r_rd_pipe[0], w_rd_issue};
    end
  end

  // Response FIFO pointers and occupancy.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CW'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop_head) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop_head})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Response FIFO storage.
  always_ff @(posedge CLK) begin
    if (RESETN && w_push) begin
      r_mem[r_wr_ptr] <= sp_do;
    end
  end

  // SP reset follows RESETN one edge later.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_sp_reset <= 1'b1;
    end else begin
      r_sp_reset <= 1'b0;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_rdata = w_rsp_rdata;
  assign sp_ce         = w_issue;
  assign sp_wre        = w_issue & bus.req_we;
  assign sp_oce        = READ_MODE & r_rd_pipe[0];
  assign sp_reset      = r_sp_reset;
  assign sp_ad         = w_ad;
  assign sp_di         = bus.req_wdata;

  sp_bsram_port_ctrl_chk #(
    .RSP_DEPTH (RSP_DEPTH),
    .CW        (CW)
  ) u_chk (
    .clk       (CLK),
    .rst_n     (RESETN),
    .push      (w_push),
    .pop       (w_pop_head),
    .count     (r_count),
    .rsp_valid (w_rsp_valid),
    .rsp_ready (bus.rsp_ready),
    .rsp_rdata (w_rsp_rdata)
  );
endmodule
